// File: rtl/pds_pkg.sv
// Shared types and constants for the ZTEX 2.13 PDS slave card.
// Contents: FSM state enum, card-select defaults, ROM window tag and the
// siz/A[1:0] -> byte-lane enable helper (be[3] is D[31:24], byte lane 0).
package pds_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_ACK,
        ST_RECOVER
    } state_t;

    localparam logic [7:0]  PDS_CARD_BASE = 8'hF9;
    localparam logic [11:0] ROM_WINDOW    = 12'hFFF;
    localparam int unsigned DATA_W        = 32;

    // Lanes a..min(3, a+n-1) where n = 4 for siz=00, else siz.
    function automatic logic [3:0] byte_en(input logic [1:0] siz, input logic [1:0] a);
        logic [2:0] n;
        logic [2:0] last;
        logic [3:0] be;
        n    = (siz == 2'b00) ? 3'd4 : {1'b0, siz};
        last = {1'b0, a} + n - 3'd1;
        if (last > 3'd3) last = 3'd3;
        be = 4'b0000;
        for (int l = 0; l < 4; l++) begin
            if (3'(l) >= {1'b0, a} && 3'(l) <= last) be[2'(3 - l)] = 1'b1;
        end
        return be;
    endfunction

endpackage

// File: rtl/pds_if.sv
// Memory request bus between the PDS bus controller (master) and pds_mem (slave).
// req: access strobe, we: write, rom_sel: ROM window, ram_idx/rom_idx: word
// indices, be: byte enables (be[3] = wdata[31:24]), wdata/rdata: 32-bit data.
interface pds_if #(
    parameter int unsigned RAM_AW = 10,
    parameter int unsigned ROM_AW = 10
);
    logic              req;
    logic              we;
    logic              rom_sel;
    logic [RAM_AW-1:0] ram_idx;
    logic [ROM_AW-1:0] rom_idx;
    logic [3:0]        be;
    logic [31:0]       wdata;
    logic [31:0]       rdata;

    modport master (output req, we, rom_sel, ram_idx, rom_idx, be, wdata, input rdata);
    modport slave  (input req, we, rom_sel, ram_idx, rom_idx, be, wdata, output rdata);
endinterface

// File: rtl/pds_mem.sv
// Card memories: byte-writable 32-bit RAM plus read-only declaration ROM.
// Ports: clk, mif (pds_if slave). Read latency is one clock; rdata holds the
// word of the last request. ROM writes are dropped.
module pds_mem #(
    parameter int unsigned RAM_WORDS = 1024,
    parameter int unsigned ROM_WORDS = 1024
) (
    input logic  clk,
    pds_if.slave mif
);

    // Declaration ROM image; all zeros when no card image is supplied.
    localparam logic [31:0] ROM_IMAGE [ROM_WORDS] = '{default: 32'h0};

    logic [31:0] ram [RAM_WORDS];
    logic [31:0] rdata_q;

    // Read-before-write port; read data is the word prior to this access.
    always_ff @(posedge clk) begin
        if (mif.req) begin
            if (mif.we && !mif.rom_sel) begin
                for (int b = 0; b < 4; b++) begin
                    if (mif.be[b]) ram[mif.ram_idx][8*b +: 8] <= mif.wdata[8*b +: 8];
                end
            end
            rdata_q <= mif.rom_sel ? ROM_IMAGE[mif.rom_idx] : ram[mif.ram_idx];
        end
    end

    assign mif.rdata = rdata_q;

endmodule

// File: rtl/ztex213_pds_v1_0.sv
// 68030 PDS slave top: card decode, bus FSM, STERM/D/HALT tristate control.
// Ports: cpuclk/reset (sync, active-high); A_3v3, rw/as/ds, siz, fc inputs;
// D_3v3, sterm, halt inouts driven by the card; dsack/berr/irq1 always high-Z;
// user_led0 toggles per terminated cycle, user_led1 marks HALT released.
module ztex213_pds_v1_0
    import pds_pkg::*;
#(
    parameter int unsigned RAM_WORDS = 1024,
    parameter int unsigned ROM_WORDS = 1024,
    parameter logic [7:0]  CARD_BASE = PDS_CARD_BASE,
    parameter int unsigned HALT_HOLD = 16
) (
    input  logic        cpuclk,
    input  logic        reset,
    input  logic [31:0] A_3v3,
    inout  wire  [31:0] D_3v3,
    input  logic        rw_3v3_n,
    input  logic        as_3v3_n,
    input  logic        ds_3v3_n,
    input  logic [1:0]  siz_3v3,
    input  logic [2:0]  fc_3v3,
    inout  wire         sterm_3v3_n,
    inout  wire  [1:0]  dsack_3v3_n,
    inout  wire         berr_3v3_n,
    inout  wire         irq1_3v3_n,
    inout  wire         halt_3v3_n,
    output logic        user_led0,
    output logic        user_led1
);

    localparam int unsigned RAM_AW = $clog2(RAM_WORDS);
    localparam int unsigned ROM_AW = $clog2(ROM_WORDS);
    localparam int unsigned HCW    = $clog2(HALT_HOLD + 1);

    pds_if #(.RAM_AW(RAM_AW), .ROM_AW(ROM_AW)) mif ();

    pds_mem #(.RAM_WORDS(RAM_WORDS), .ROM_WORDS(ROM_WORDS)) u_mem (
        .clk (cpuclk),
        .mif (mif)
    );

    state_t           state_q, state_d;
    logic             rw_q, rw_d;
    logic             sterm_oe_q, sterm_oe_d;
    logic             sterm_lvl_q, sterm_lvl_d;
    logic             d_oe_q, d_oe_d;
    logic [DATA_W-1:0] d_out_q, d_out_d;
    logic             led0_q, led0_d;
    logic [HCW-1:0]   halt_cnt_q, halt_cnt_d;
    logic             halt_rel_q, halt_rel_d;
    logic             sel_c;

    // Card decode; the memory access is issued on the same edge that samples the strobes.
    always_comb begin
        sel_c = !as_3v3_n && !ds_3v3_n && (A_3v3[31:24] == CARD_BASE) && (fc_3v3 != 3'b111);
        mif.req     = (state_q == ST_IDLE) && sel_c;
        mif.we      = !rw_3v3_n;
        mif.rom_sel = (A_3v3[23:12] == ROM_WINDOW);
        mif.ram_idx = A_3v3[RAM_AW+1:2];
        mif.rom_idx = A_3v3[ROM_AW+1:2];
        mif.be      = byte_en(siz_3v3, A_3v3[1:0]);
        mif.wdata   = D_3v3;
    end

    // Next-state and registered bus-pin controls.
    always_comb begin
        state_d     = state_q;
        rw_d        = rw_q;
        sterm_oe_d  = sterm_oe_q;
        sterm_lvl_d = sterm_lvl_q;
        d_oe_d      = d_oe_q;
        d_out_d     = d_out_q;
        led0_d      = led0_q;
        halt_cnt_d  = halt_cnt_q;
        halt_rel_d  = halt_rel_q;

        case (state_q)
            ST_IDLE: begin
                if (sel_c) begin
                    state_d = ST_ACCESS;
                    rw_d    = rw_3v3_n;
                end
            end
            ST_ACCESS: begin
                state_d     = ST_ACK;
                sterm_oe_d  = 1'b1;
                sterm_lvl_d = 1'b0;
                d_oe_d      = rw_q;
                d_out_d     = mif.rdata;
                led0_d      = !led0_q;
            end
            ST_ACK: begin
                // Hold termination until the master drops AS.
                if (as_3v3_n) begin
                    state_d     = ST_RECOVER;
                    sterm_lvl_d = 1'b1;
                    d_oe_d      = 1'b0;
                end
            end
            ST_RECOVER: begin
                state_d    = ST_IDLE;
                sterm_oe_d = 1'b0;
            end
            default: state_d = ST_IDLE;
        endcase

        // HALT hold-off counter; freezes once released.
        if (!halt_rel_q) begin
            if (halt_cnt_q == HCW'(HALT_HOLD - 1)) halt_rel_d = 1'b1;
            halt_cnt_d = HCW'(halt_cnt_q + 1'b1);
        end
    end

    always_ff @(posedge cpuclk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            rw_q        <= 1'b1;
            sterm_oe_q  <= 1'b0;
            sterm_lvl_q <= 1'b1;
            d_oe_q      <= 1'b0;
            d_out_q     <= '0;
            led0_q      <= 1'b0;
            halt_cnt_q  <= '0;
            halt_rel_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            rw_q        <= rw_d;
            sterm_oe_q  <= sterm_oe_d;
            sterm_lvl_q <= sterm_lvl_d;
            d_oe_q      <= d_oe_d;
            d_out_q     <= d_out_d;
            led0_q      <= led0_d;
            halt_cnt_q  <= halt_cnt_d;
            halt_rel_q  <= halt_rel_d;
        end
    end

    assign D_3v3       = d_oe_q ? d_out_q : {DATA_W{1'bz}};
    assign sterm_3v3_n = sterm_oe_q ? sterm_lvl_q : 1'bz;
    assign halt_3v3_n  = halt_rel_q ? 1'bz : 1'b0;
    assign dsack_3v3_n = 2'bzz;
    assign berr_3v3_n  = 1'bz;
    assign irq1_3v3_n  = 1'bz;
    assign user_led0   = led0_q;
    assign user_led1   = halt_rel_q;

endmodule

// File: tb/tb_ztex213_pds_v1_0.sv
// Bench for the PDS slave: directed bus cycles then randomized cycles, checked
// against a word-array model of card memory. Bus pins use pull-ups so a
// released (high-Z) pin reads as all ones.
module tb_ztex213_pds_v1_0;

    logic        cpuclk = 1'b0;
    logic        reset;
    logic [31:0] a;
    logic        rw_n, as_n, ds_n;
    logic [1:0]  siz;
    logic [2:0]  fc;
    logic        d_drv;
    logic [31:0] d_val;
    tri1  [31:0] d_bus;
    tri1         sterm_n;
    tri1  [1:0]  dsack_n;
    tri1         berr_n;
    tri1         irq1_n;
    tri1         halt_n;
    logic        led0, led1;

    int          total;
    int          bad;
    logic [31:0] ram_m [1024];
    logic        led0_m;

    always #5 cpuclk = ~cpuclk;

    assign d_bus = d_drv ? d_val : 32'hzzzz_zzzz;

    ztex213_pds_v1_0 dut (
        .cpuclk      (cpuclk),
        .reset       (reset),
        .A_3v3       (a),
        .D_3v3       (d_bus),
        .rw_3v3_n    (rw_n),
        .as_3v3_n    (as_n),
        .ds_3v3_n    (ds_n),
        .siz_3v3     (siz),
        .fc_3v3      (fc),
        .sterm_3v3_n (sterm_n),
        .dsack_3v3_n (dsack_n),
        .berr_3v3_n  (berr_n),
        .irq1_3v3_n  (irq1_n),
        .halt_3v3_n  (halt_n),
        .user_led0   (led0),
        .user_led1   (led1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // One master cycle starting just after a falling edge; returns in IDLE-ready time.
    task automatic bus_cycle(input logic [31:0] addr, input logic rd, input logic [1:0] sz,
                             input logic [2:0] f, input logic [31:0] wd, input int hold,
                             input string tag);
        logic        sel;
        logic        rom;
        logic [31:0] exp_rd;
        int          n;
        int          lo;
        sel    = (addr[31:24] == 8'hF9) && (f != 3'd7);
        rom    = (addr[23:12] == 12'hFFF);
        exp_rd = rom ? 32'h0 : ram_m[addr[11:2]];

        a = addr; rw_n = rd; siz = sz; fc = f; as_n = 1'b0; ds_n = 1'b0;
        d_drv = !rd; d_val = wd;

        @(posedge cpuclk); @(negedge cpuclk);
        check({tag, "_e0_sterm"}, 32'(sterm_n), 32'd1);

        @(posedge cpuclk); @(negedge cpuclk);
        check({tag, "_e1_sterm"}, 32'(sterm_n), sel ? 32'd0 : 32'd1);
        if (rd) check({tag, "_e1_data"}, d_bus, sel ? exp_rd : 32'hFFFF_FFFF);
        if (sel) led0_m = !led0_m;
        check({tag, "_led0"}, 32'(led0), 32'(led0_m));

        if (!rd && sel && !rom) begin
            n  = (sz == 2'b00) ? 4 : int'(sz);
            lo = int'(addr[1:0]);
            for (int k = lo; k < 4 && k < lo + n; k++)
                ram_m[addr[11:2]][31-8*k -: 8] = wd[31-8*k -: 8];
        end

        for (int h = 0; h < hold; h++) begin
            @(posedge cpuclk); @(negedge cpuclk);
            check({tag, "_hold_sterm"}, 32'(sterm_n), sel ? 32'd0 : 32'd1);
            if (rd) check({tag, "_hold_data"}, d_bus, sel ? exp_rd : 32'hFFFF_FFFF);
        end

        as_n = 1'b1; ds_n = 1'b1; d_drv = 1'b0;
        @(posedge cpuclk); @(negedge cpuclk);
        check({tag, "_rec_sterm"}, 32'(sterm_n), 32'd1);
        check({tag, "_rec_data"}, d_bus, 32'hFFFF_FFFF);
        @(posedge cpuclk); @(negedge cpuclk);
        check({tag, "_idle_sterm"}, 32'(sterm_n), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rv;
        total = 0; bad = 0; led0_m = 1'b0;
        reset = 1'b1; a = '0; rw_n = 1'b1; as_n = 1'b1; ds_n = 1'b1;
        siz = 2'b00; fc = 3'd0; d_drv = 1'b0; d_val = '0;

        // Reset state and HALT release timing.
        repeat (3) @(posedge cpuclk);
        #1;
        check("rst_halt", 32'(halt_n), 32'd0);
        check("rst_led0", 32'(led0), 32'd0);
        check("rst_led1", 32'(led1), 32'd0);
        check("rst_sterm", 32'(sterm_n), 32'd1);
        check("rst_data", d_bus, 32'hFFFF_FFFF);
        check("rst_dsack", 32'(dsack_n), 32'd3);
        check("rst_berr", 32'(berr_n), 32'd1);
        check("rst_irq1", 32'(irq1_n), 32'd1);
        @(negedge cpuclk); reset = 1'b0;
        repeat (15) @(posedge cpuclk);
        #1;
        check("halt_15", 32'(halt_n), 32'd0);
        check("led1_15", 32'(led1), 32'd0);
        @(posedge cpuclk);
        #1;
        check("halt_16", 32'(halt_n), 32'd1);
        check("led1_16", 32'(led1), 32'd1);
        @(negedge cpuclk);

        // Long writes and reads.
        bus_cycle(32'hF900_0000, 1'b0, 2'b00, 3'd0, 32'h8765_4321, 0, "lw0");
        bus_cycle(32'hF900_0004, 1'b0, 2'b00, 3'd0, 32'h789A_BCDE, 0, "lw1");
        bus_cycle(32'hF900_0008, 1'b0, 2'b00, 3'd0, 32'h7795_B3D1, 0, "lw2");
        bus_cycle(32'hF900_000C, 1'b0, 2'b00, 3'd0, 32'h886A_4C2E, 0, "lw3");
        bus_cycle(32'hF900_0000, 1'b1, 2'b00, 3'd0, 32'h0, 0, "lr0");
        bus_cycle(32'hF900_0004, 1'b1, 2'b00, 3'd0, 32'h0, 1, "lr1");
        bus_cycle(32'hF900_0008, 1'b1, 2'b00, 3'd0, 32'h0, 0, "lr2");
        bus_cycle(32'hF900_000C, 1'b1, 2'b00, 3'd0, 32'h0, 2, "lr3");

        // Byte-lane write over a known word, then word and byte sizes at edges.
        bus_cycle(32'hF900_0010, 1'b0, 2'b00, 3'd0, 32'h1122_3344, 0, "bw_init");
        bus_cycle(32'hF900_0011, 1'b0, 2'b01, 3'd0, 32'hA55A_C33C, 0, "bw_byte");
        bus_cycle(32'hF900_0010, 1'b1, 2'b00, 3'd0, 32'h0, 0, "bw_read");
        bus_cycle(32'hF900_0013, 1'b0, 2'b11, 3'd0, 32'hDEAD_BEEF, 0, "bw_clip");
        bus_cycle(32'hF900_0010, 1'b1, 2'b00, 3'd0, 32'h0, 0, "bw_read2");

        // ROM window: write is acknowledged and dropped.
        bus_cycle(32'hF9FF_F000, 1'b0, 2'b00, 3'd0, 32'hCAFE_F00D, 0, "rom_wr");
        bus_cycle(32'hF9FF_F000, 1'b1, 2'b00, 3'd0, 32'h0, 0, "rom_rd");

        // Cycles that belong to someone else.
        bus_cycle(32'hFA00_0000, 1'b1, 2'b00, 3'd0, 32'h0, 0, "nr_base");
        bus_cycle(32'hF900_0000, 1'b0, 2'b00, 3'd7, 32'h0BAD_0BAD, 0, "nr_fc7w");
        bus_cycle(32'hF900_0000, 1'b1, 2'b00, 3'd7, 32'h0, 0, "nr_fc7r");
        bus_cycle(32'hF900_0000, 1'b1, 2'b00, 3'd2, 32'h0, 0, "nr_after");

        // Reset while STERM is asserted.
        a = 32'hF900_0004; rw_n = 1'b1; siz = 2'b00; fc = 3'd0; as_n = 1'b0; ds_n = 1'b0;
        @(posedge cpuclk); @(posedge cpuclk); @(negedge cpuclk);
        check("mid_ack_sterm", 32'(sterm_n), 32'd0);
        check("mid_ack_data", d_bus, ram_m[1]);
        reset = 1'b1;
        @(posedge cpuclk); @(negedge cpuclk);
        check("mid_rst_sterm", 32'(sterm_n), 32'd1);
        check("mid_rst_data", d_bus, 32'hFFFF_FFFF);
        check("mid_rst_led0", 32'(led0), 32'd0);
        check("mid_rst_halt", 32'(halt_n), 32'd0);
        led0_m = 1'b0;
        as_n = 1'b1; ds_n = 1'b1; reset = 1'b0;
        repeat (17) @(posedge cpuclk);
        @(negedge cpuclk);
        check("rerel_halt", 32'(halt_n), 32'd1);
        bus_cycle(32'hF900_0004, 1'b1, 2'b00, 3'd0, 32'h0, 0, "post_rst");

        // Randomized traffic over a small aliased working set.
        for (int i = 0; i < 16; i++)
            bus_cycle({8'hF9, 12'h000, 6'd0, 4'(i), 2'b00}, 1'b0, 2'b00, 3'd1, $urandom, 0, "rinit");
        for (int i = 0; i < 48; i++) begin
            logic [7:0]  base;
            logic [11:0] up;
            rv   = $urandom;
            base = (rv[2:0] == 3'd0) ? 8'($urandom) : 8'hF9;
            up   = (rv[5:3] == 3'd0) ? 12'hFFF : 12'($urandom);
            bus_cycle({base, up, 6'd0, 4'($urandom), 2'($urandom)}, 1'($urandom),
                      2'($urandom), 3'($urandom), $urandom, int'($urandom_range(0, 2)), "rnd");
        end
        for (int i = 0; i < 16; i++)
            bus_cycle({8'hF9, 12'h123, 6'd0, 4'(i), 2'b00}, 1'b1, 2'b00, 3'd5, 32'h0, 0, "rfinal");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
